// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the 3x3 convolution window feeder.
package conv_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int KERNEL_DIM  = 3;

    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_FLUSH = ST_FLUSH,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap/column/row walker for stride-1 unpadded 3x3 windows; produces the pixel
// address and weight index of the current tap plus a last-beat flag.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 6,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        w_idx,
    output logic              last_beat
);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - KERNEL_DIM);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - KERNEL_DIM);
    localparam logic [1:0]        K_LAST   = 2'(KERNEL_DIM - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

    // Tap is kept as (kernel row, kernel col) so no divide by 3 is needed.
    logic [1:0]       kr_q, kr_d;
    logic [1:0]       kc_q, kc_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Counter advance with nested wraps: tap -> window column -> window row.
    always_comb begin
        kr_d  = kr_q;
        kc_d  = kc_q;
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            kr_d  = 2'd0;
            kc_d  = 2'd0;
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (kc_q == K_LAST) begin
                kc_d = 2'd0;
                if (kr_q == K_LAST) begin
                    kr_d = 2'd0;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    kr_d = kr_q + 2'd1;
                end
            end else begin
                kc_d = kc_q + 2'd1;
            end
        end else begin
            kc_d = kc_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kr_q  <= 2'd0;
            kc_q  <= 2'd0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            kr_q  <= kr_d;
            kc_q  <= kc_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign w_idx     = 4'(kr_q) * 4'(KERNEL_DIM) + 4'(kc_q);
    assign pix_addr  = (ADDR_W'(row_q) + ADDR_W'(kr_q)) * IMG_W_A
                     + ADDR_W'(col_q) + ADDR_W'(kc_q);
    assign last_beat = (kr_q == K_LAST) && (kc_q == K_LAST)
                     && (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/conv_window_feeder.sv
// Streams truncated pixel*weight products for every 3x3 window of a stored
// image into a downstream accumulator, followed by one zero flush beat.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              hold,
    output logic              acc_valid,
    output logic [DATA_W-1:0] acc_in,
    output logic              flush,
    output logic [2:0]        win_row,
    output logic [2:0]        win_col,
    output logic              busy,
    output logic              done
);

    localparam int               NPIX   = IMG_W * IMG_H;
    localparam int               COL_W  = $clog2(IMG_W);
    localparam int               ROW_W  = $clog2(IMG_H);
    localparam logic [ADDR_W:0]  NPIX_L = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] W_MAX = ADDR_W'(KERNEL_TAPS - 1);

    logic [DATA_W-1:0] pix_mem [NPIX];
    logic [DATA_W-1:0] w_mem   [KERNEL_TAPS];

    state_e            state_q, state_d;
    logic              acc_valid_q, acc_valid_d;
    logic [DATA_W-1:0] acc_in_q, acc_in_d;
    logic              flush_q, flush_d;
    logic [2:0]        win_row_q, win_row_d;
    logic [2:0]        win_col_q, win_col_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              gen_clear_s, gen_step_s, last_beat_s;
    logic [COL_W-1:0]  col_s;
    logic [ROW_W-1:0]  row_s;
    logic [ADDR_W-1:0] pix_addr_s;
    logic [3:0]        w_idx_s;
    logic              pix_we_s, w_we_s;
    logic [DATA_W-1:0] prod_s;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (gen_clear_s),
        .step      (gen_step_s),
        .col       (col_s),
        .row       (row_s),
        .pix_addr  (pix_addr_s),
        .w_idx     (w_idx_s),
        .last_beat (last_beat_s)
    );

    assign pix_we_s = cfg_we && (state_q == S_IDLE) && !cfg_sel
                    && ({1'b0, cfg_addr} < NPIX_L);
    assign w_we_s   = cfg_we && (state_q == S_IDLE) && cfg_sel
                    && (cfg_addr <= W_MAX);

    // Storage is deliberately not reset; only writes from IDLE land.
    always_ff @(posedge clk) begin
        if (pix_we_s) begin
            pix_mem[cfg_addr] <= cfg_data;
        end
        if (w_we_s) begin
            w_mem[cfg_addr[3:0]] <= cfg_data;
        end
    end

    // Product in DATA_W-bit context keeps only the low bits.
    assign prod_s = pix_mem[pix_addr_s] * w_mem[w_idx_s];

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        acc_valid_d = 1'b0;
        acc_in_d    = acc_in_q;
        flush_d     = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gen_clear_s = 1'b0;
        gen_step_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Tap 0 of window (0,0) issues in the start cycle for
                    // single-cycle latency.
                    acc_valid_d = 1'b1;
                    acc_in_d    = prod_s;
                    win_row_d   = 3'(row_s);
                    win_col_d   = 3'(col_s);
                    gen_step_s  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end else begin
                    gen_clear_s = 1'b1;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    acc_valid_d = 1'b1;
                    acc_in_d    = prod_s;
                    win_row_d   = 3'(row_s);
                    win_col_d   = 3'(col_s);
                    gen_step_s  = 1'b1;
                    if (last_beat_s) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (!hold) begin
                    acc_valid_d = 1'b1;
                    acc_in_d    = '0;
                    flush_d     = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_valid_q <= 1'b0;
            acc_in_q    <= '0;
            flush_q     <= 1'b0;
            win_row_q   <= 3'd0;
            win_col_q   <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_valid_q <= acc_valid_d;
            acc_in_q    <= acc_in_d;
            flush_q     <= flush_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_in    = acc_in_q;
    assign flush     = flush_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a reference model fills a queue of
// expected beats per pass; a negedge monitor pops and compares each beat.
module tb_conv_window_feeder;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NB   = (H - 2) * (W - 2) * 9 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we, cfg_sel, start, hold;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       acc_valid, flush, busy, done;
    logic [7:0] acc_in;
    logic [2:0] win_row, win_col;

    typedef struct {
        int acc;
        bit fl;
        int r;
        int c;
    } beat_t;

    beat_t expq[$];
    int    pix_m[W*H];
    int    w_m[9];
    int    errors = 0;
    int    checks = 0;
    int    beat_cnt = 0;
    int    cyc = 0;
    bit    expect_done = 1'b0;

    conv_window_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .hold      (hold),
        .acc_valid (acc_valid),
        .acc_in    (acc_in),
        .flush     (flush),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: compare every presented beat against the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (done !== expect_done || (done && busy)) begin
                errors++;
                $display("FAIL done_pulse: done=%0b busy=%0b, want done=%0b busy=0",
                         done, busy, expect_done);
            end
            expect_done = 1'b0;
            if (acc_valid) begin
                beat_t e;
                beat_cnt++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: beat %0d acc_in=%0d flush=%0b, want no beat",
                             beat_cnt, acc_in, flush);
                end else begin
                    e = expq.pop_front();
                    if (int'(acc_in) != e.acc || flush != e.fl || int'(win_row) != e.r
                        || int'(win_col) != e.c || busy != 1'b1) begin
                        errors++;
                        $display("FAIL beat%0d: acc_in=%0d flush=%0b row=%0d col=%0d busy=%0b, want acc_in=%0d flush=%0b row=%0d col=%0d busy=1",
                                 beat_cnt, acc_in, flush, win_row, win_col, busy,
                                 e.acc, e.fl, e.r, e.c);
                    end
                    if (e.fl) expect_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic build_exp();
        expq.delete();
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                for (int t = 0; t < 9; t++) begin
                    beat_t b;
                    b.acc = (pix_m[(r + t / 3) * W + c + t % 3] * w_m[t]) % 256;
                    b.fl  = 1'b0;
                    b.r   = r;
                    b.c   = c;
                    expq.push_back(b);
                end
        expq.push_back('{acc: 0, fl: 1'b1, r: H - 3, c: W - 3});
    endtask

    task automatic load_all();
        for (int a = 0; a < W * H; a++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'(a); cfg_data = 8'(pix_m[a]);
        end
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'(t); cfg_data = 8'(w_m[t]);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (beat_cnt >= n) break;
            @(negedge clk);
            #1;
        end
        check("wait_beats_timeout", beat_cnt >= n, 1);
    endtask

    task automatic kick();
        beat_cnt = 0;
        build_exp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("first_beat_latency", int'({acc_valid, busy}), 3);
    endtask

    task automatic finish_pass(input int c0, input int stall);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
            #1;
        end
        check("done_seen", int'(done), 1);
        check("pass_cycles", cyc - c0, NB + stall);
        check("beat_count", beat_cnt, NB);
        check("queue_empty", expq.size(), 0);
        @(negedge clk);
        #1;
        check("idle_after_done", int'({busy, done}), 0);
    endtask

    task automatic run_pass(input int hold_at);
        int c0;
        int stall;
        stall = 0;
        kick();
        c0 = cyc;
        if (hold_at >= 0) begin
            wait_beats(hold_at);
            hold = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                check("no_valid_in_hold", int'(acc_valid), 0);
            end
            hold = 1'b0;
            stall = 4;
        end
        finish_pass(c0, stall);
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd0;
        start = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({acc_valid, acc_in, flush, win_row, win_col, busy, done}), 0);
        rst = 1'b1;

        // All ones.
        foreach (pix_m[a]) pix_m[a] = 1;
        foreach (w_m[t]) w_m[t] = 1;
        load_all();
        run_pass(-1);

        // Centre tap only: picks out each window's centre pixel.
        foreach (pix_m[a]) pix_m[a] = a;
        foreach (w_m[t]) w_m[t] = (t == 4) ? 1 : 0;
        load_all();
        run_pass(-1);

        // Truncation: 16*16 wraps to 0, 15*17 stays 255.
        foreach (pix_m[a]) pix_m[a] = 16;
        foreach (w_m[t]) w_m[t] = 16;
        load_all();
        run_pass(-1);
        foreach (pix_m[a]) pix_m[a] = 15;
        foreach (w_m[t]) w_m[t] = 17;
        load_all();
        run_pass(-1);

        // Random data, out-of-range kernel writes, hold at beat 5.
        foreach (pix_m[a]) pix_m[a] = int'($urandom_range(0, 255));
        foreach (w_m[t]) w_m[t] = int'($urandom_range(0, 255));
        load_all();
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'd9; cfg_data = 8'($urandom);
        @(negedge clk);
        cfg_addr = 6'd63; cfg_data = 8'($urandom);
        @(negedge clk);
        cfg_we = 1'b0;
        run_pass(5);

        // Abort: ignored start and config write while busy, then reset mid-pass.
        foreach (pix_m[a]) pix_m[a] = int'($urandom_range(0, 255));
        foreach (w_m[t]) w_m[t] = int'($urandom_range(1, 255));
        w_m[0] = 1;
        load_all();
        kick();
        wait_beats(100);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_beats(120);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = 8'(~pix_m[0]);
        @(negedge clk);
        #1;
        cfg_we = 1'b0;
        wait_beats(200);
        check("beats_before_abort", beat_cnt, 200);
        rst = 1'b0;
        #1;
        check("abort_outputs", int'({acc_valid, acc_in, flush, win_row, win_col, busy, done}), 0);
        expq.delete();
        expect_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("no_done_after_abort", int'({acc_valid, done}), 0);
        rst = 1'b1;
        run_pass(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
